// File: rtl/uart_rx_framer_if.sv
// AXI-Stream byte bundle for the UART receive framer.
// Carries the upstream byte stream (s_axis_*) and the downstream payload
// stream (m_axis_*). "master" is the environment side (byte source and
// payload sink), "slave" is the framer side.
interface uart_rx_framer_if #(
   parameter int W = 8
);
   logic [W-1:0] s_axis_tdata;
   logic         s_axis_tvalid;
   logic         s_axis_tready;
   logic [W-1:0] m_axis_tdata;
   logic         m_axis_tvalid;
   logic         m_axis_tlast;
   logic         m_axis_tuser;
   logic         m_axis_tready;

   modport master (
      output s_axis_tdata, s_axis_tvalid, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
   );

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
   );
endinterface

// File: rtl/uart_rx_framer.sv
// UART receive framer: parses SOF / LEN / payload / XOR-CHK frames from a
// byte stream and re-emits each payload as one AXI-Stream packet. The last
// payload byte is held back until CHK arrives so that tlast/tuser can carry
// the frame verdict. Mid-frame upstream silence aborts the frame.
module uart_rx_framer #(
   parameter int         AXIS_WIDTH     = 8,
   parameter logic [7:0] SOF_BYTE       = 8'hA5,
   parameter int         MAX_LEN        = 16,
   parameter int         TIMEOUT_CYCLES = 2000000
) (
   input  logic              clk,
   input  logic              rstn,
   uart_rx_framer_if.slave   bus,
   output logic              frame_ok,
   output logic              frame_err,
   output logic [1:0]        err_code
);
   localparam int             TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]  TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_LEN     = 3'd1;
   localparam logic [2:0] S_PAYLOAD = 3'd2;
   localparam logic [2:0] S_CHK     = 3'd3;
   localparam logic [2:0] S_FLUSH   = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [7:0]            len_q, len_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [7:0]            chk_q, chk_d;
   logic [TW-1:0]         to_q, to_d;
   logic [AXIS_WIDTH-1:0] tdata_q, tdata_d;
   logic                  tvalid_q, tvalid_d;
   logic                  tlast_q, tlast_d;
   logic                  tuser_q, tuser_d;
   logic                  pend_q, pend_d;     // FLUSH has a held last byte to release
   logic                  ok_q, ok_d;
   logic                  err_q, err_d;
   logic [1:0]            code_q, code_d;

   logic       s_ready;
   logic       free;
   logic       accept;
   logic       in_frame;
   logic       timeout;
   logic [7:0] in_byte;

   assign in_byte  = bus.s_axis_tdata;
   assign free     = !tvalid_q || bus.m_axis_tready;
   assign accept   = bus.s_axis_tvalid && s_ready;
   assign in_frame = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHK);
   assign timeout  = in_frame && !bus.s_axis_tvalid && (to_q == TO_LAST);

   // Upstream ready: payload bytes only enter when the output stage can take them.
   always_comb begin
      s_ready = 1'b0;
      case (state_q)
         S_IDLE, S_LEN, S_CHK: s_ready = 1'b1;
         S_PAYLOAD:            s_ready = free;
         default:              s_ready = 1'b0;
      endcase
   end

   // Next-state logic for the frame parser, output stage and status pulses.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      chk_d    = chk_q;
      tdata_d  = tdata_q;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      tuser_d  = tuser_q;
      pend_d   = pend_q;
      ok_d     = 1'b0;
      err_d    = 1'b0;
      code_d   = code_q;

      // A transferred beat frees the output stage; data is left as-is.
      if (tvalid_q && bus.m_axis_tready) begin
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
         tuser_d  = 1'b0;
      end

      // Silence counter only runs mid-frame and only while upstream is idle.
      if (!in_frame || accept) begin
         to_d = '0;
      end else if (!bus.s_axis_tvalid) begin
         to_d = to_q + TW'(1);
      end else begin
         to_d = to_q;
      end

      case (state_q)
         S_IDLE: begin
            if (accept && in_byte == SOF_BYTE) state_d = S_LEN;
         end
         S_LEN: begin
            if (accept) begin
               len_d = in_byte;
               chk_d = in_byte;
               if (in_byte == 8'd0 || in_byte > MAX_LEN_B) begin
                  err_d   = 1'b1;
                  code_d  = 2'd1;
                  state_d = S_IDLE;
               end else begin
                  cnt_d   = 8'd0;
                  state_d = S_PAYLOAD;
               end
            end else if (timeout) begin
               err_d   = 1'b1;
               code_d  = 2'd3;
               state_d = S_IDLE;
            end
         end
         S_PAYLOAD: begin
            if (accept) begin
               chk_d   = chk_q ^ in_byte;
               tdata_d = AXIS_WIDTH'(in_byte);
               cnt_d   = cnt_q + 8'd1;
               tlast_d = 1'b0;
               tuser_d = 1'b0;
               // The final byte waits invisibly for the checksum verdict.
               if (cnt_q + 8'd1 == len_q) begin
                  tvalid_d = 1'b0;
                  state_d  = S_CHK;
               end else begin
                  tvalid_d = 1'b1;
               end
            end else if (timeout) begin
               err_d  = 1'b1;
               code_d = 2'd3;
               pend_d = 1'b0;
               state_d = (cnt_q == 8'd0) ? S_IDLE : S_FLUSH;
            end
         end
         S_CHK: begin
            if (accept) begin
               tvalid_d = 1'b1;
               tlast_d  = 1'b1;
               tuser_d  = (in_byte != chk_q);
               if (in_byte == chk_q) begin
                  ok_d   = 1'b1;
                  code_d = 2'd0;
               end else begin
                  err_d  = 1'b1;
                  code_d = 2'd2;
               end
               state_d = S_IDLE;
            end else if (timeout) begin
               err_d   = 1'b1;
               code_d  = 2'd3;
               pend_d  = 1'b1;
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            // Close the aborted packet with a bad-frame terminator.
            if (free) begin
               tvalid_d = 1'b1;
               tlast_d  = 1'b1;
               tuser_d  = 1'b1;
               if (!pend_q) tdata_d = '0;
               pend_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         cnt_q    <= '0;
         chk_q    <= '0;
         to_q     <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tuser_q  <= 1'b0;
         pend_q   <= 1'b0;
         ok_q     <= 1'b0;
         err_q    <= 1'b0;
         code_q   <= '0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         chk_q    <= chk_d;
         to_q     <= to_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tuser_q  <= tuser_d;
         pend_q   <= pend_d;
         ok_q     <= ok_d;
         err_q    <= err_d;
         code_q   <= code_d;
      end
   end

   assign bus.s_axis_tready = s_ready;
   assign bus.m_axis_tdata  = tdata_q;
   assign bus.m_axis_tvalid = tvalid_q;
   assign bus.m_axis_tlast  = tlast_q;
   assign bus.m_axis_tuser  = tuser_q;
   assign frame_ok          = ok_q;
   assign frame_err         = err_q;
   assign err_code          = code_q;
endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: directed frames from the test plan
// followed by random frame batches under random downstream backpressure.
// Expected beats and status events come from a frame-level reference parser.
module tb_uart_rx_framer;
   localparam logic [7:0] SOF     = 8'hA5;
   localparam int         MAXLEN  = 16;
   localparam int         TIMEOUT = 20;

   logic       clk = 1'b0;
   logic       rstn;
   logic       frame_ok, frame_err;
   logic [1:0] err_code;

   int n_tests = 0;
   int n_fail  = 0;
   bit bp_en   = 1'b0;

   // Beat = {tuser, tlast, data}; status = {frame_ok, frame_err, err_code}.
   logic [9:0] obs_beats[$], exp_beats[$];
   logic [3:0] obs_stat[$],  exp_stat[$];
   logic [7:0] stim[$];

   uart_rx_framer_if #(.W(8)) bus ();

   uart_rx_framer #(
      .AXIS_WIDTH(8), .SOF_BYTE(SOF), .MAX_LEN(MAXLEN), .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk(clk), .rstn(rstn), .bus(bus),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Random downstream backpressure, applied away from the main thread's drive point.
   always begin
      @(posedge clk);
      #2;
      if (bp_en) bus.m_axis_tready = 1'($urandom_range(1, 0));
   end

   // Output monitor: records transfers and status pulses, checks held-beat stability.
   initial begin
      logic       held;
      logic [9:0] hb, cur;
      held = 1'b0;
      hb   = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            held = 1'b0;
         end else begin
            cur = {bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata};
            if (held) begin
               check("held beat valid", {31'd0, bus.m_axis_tvalid}, 32'd1);
               check("held beat stable", {22'd0, cur}, {22'd0, hb});
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) obs_beats.push_back(cur);
            held = bus.m_axis_tvalid && !bus.m_axis_tready;
            hb   = cur;
            if (frame_ok || frame_err) begin
               check("ok/err exclusive", {31'd0, frame_ok & frame_err}, 32'd0);
               obs_stat.push_back({frame_ok, frame_err, err_code});
            end
         end
      end
   end

   // Reference parser over a complete byte stream (no timeouts).
   task automatic model(input logic [7:0] s[$]);
      int         i, n, k;
      logic [7:0] len, c;
      logic [9:0] b;
      i = 0;
      n = s.size();
      while (i < n) begin
         if (s[i] != SOF) begin
            i++;
            continue;
         end
         i++;
         if (i >= n) break;
         len = s[i];
         i++;
         if (len == 8'd0 || int'(len) > MAXLEN) begin
            exp_stat.push_back(4'b0101);
            continue;
         end
         c = len;
         for (k = 0; k < int'(len) && i < n; k++) begin
            c = c ^ s[i];
            exp_beats.push_back({1'b0, (k == int'(len) - 1), s[i]});
            i++;
         end
         if (i >= n) break;
         b = exp_beats.pop_back();
         b[9] = (s[i] != c);
         exp_beats.push_back(b);
         exp_stat.push_back((s[i] == c) ? 4'b1000 : 4'b0110);
         i++;
      end
   endtask

   // Drive a byte list upstream; called and returns at posedge+1.
   task automatic send_bytes(input logic [7:0] q[$], input int max_gap);
      int w;
      bit acc;
      foreach (q[i]) begin
         bus.s_axis_tdata  = q[i];
         bus.s_axis_tvalid = 1'b1;
         w   = 0;
         acc = 1'b0;
         while (!acc && w < 300) begin
            @(negedge clk);
            acc = bus.s_axis_tready;
            @(posedge clk);
            #1;
            w++;
         end
         bus.s_axis_tvalid = 1'b0;
         check($sformatf("byte %0h accepted", q[i]), {31'd0, acc}, 32'd1);
         repeat ($urandom_range(max_gap, 0)) begin
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic drain(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
      bp_en = 1'b0;
      bus.m_axis_tready = 1'b1;
      repeat (6) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic compare_all(input string tag);
      int nb, ns;
      check($sformatf("%s beat count", tag), obs_beats.size(), exp_beats.size());
      check($sformatf("%s status count", tag), obs_stat.size(), exp_stat.size());
      nb = (obs_beats.size() < exp_beats.size()) ? obs_beats.size() : exp_beats.size();
      ns = (obs_stat.size() < exp_stat.size()) ? obs_stat.size() : exp_stat.size();
      for (int i = 0; i < nb; i++)
         check($sformatf("%s beat %0d", tag, i), {22'd0, obs_beats[i]}, {22'd0, exp_beats[i]});
      for (int i = 0; i < ns; i++)
         check($sformatf("%s status %0d", tag, i), {28'd0, obs_stat[i]}, {28'd0, exp_stat[i]});
      $display("[TB] %s: %0d beats, %0d status events", tag, obs_beats.size(), obs_stat.size());
      obs_beats.delete(); exp_beats.delete();
      obs_stat.delete();  exp_stat.delete();
   endtask

   initial begin
      int         k;
      logic [7:0] len, c, p, j;

      rstn = 1'b0;
      bus.s_axis_tdata  = '0;
      bus.s_axis_tvalid = 1'b0;
      bus.m_axis_tready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset s_tready", {31'd0, bus.s_axis_tready}, 32'd1);
      check("reset m_tvalid", {31'd0, bus.m_axis_tvalid}, 32'd0);
      check("reset frame_ok", {31'd0, frame_ok}, 32'd0);
      check("reset frame_err", {31'd0, frame_err}, 32'd0);
      check("reset err_code", {30'd0, err_code}, 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // Good frame.
      stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
      model(stim);
      send_bytes(stim, 0);
      drain(4);
      compare_all("good");

      // Bad checksum.
      stim = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
      model(stim);
      send_bytes(stim, 0);
      drain(4);
      compare_all("badchk");

      // Bad lengths surrounded by junk.
      stim = '{8'h00, 8'h7E, 8'hA5, 8'h00, 8'hA5, 8'h11};
      model(stim);
      send_bytes(stim, 0);
      check("badlen s_tready", {31'd0, bus.s_axis_tready}, 32'd1);
      drain(4);
      compare_all("badlen");

      // Backpressure across a 4-byte payload.
      bus.m_axis_tready = 1'b0;
      stim = '{8'hA5, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h26};
      model(stim);
      fork
         send_bytes(stim, 0);
         begin
            repeat (8) @(negedge clk);
            check("bp s_tready", {31'd0, bus.s_axis_tready}, 32'd0);
            check("bp m_tvalid", {31'd0, bus.m_axis_tvalid}, 32'd1);
            check("bp tdata held", {24'd0, bus.m_axis_tdata}, 32'hDE);
            @(posedge clk);
            #1;
            bus.m_axis_tready = 1'b1;
         end
      join
      drain(4);
      compare_all("backpressure");

      // Inter-byte timeout mid-payload, then a clean frame.
      stim = '{8'hA5, 8'h04, 8'h01, 8'h02};
      send_bytes(stim, 0);
      for (k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (frame_err) break;
      end
      check("timeout latency", {31'd0, (k == TIMEOUT || k == TIMEOUT + 1)}, 32'd1);
      @(posedge clk);
      #1;
      drain(4);
      exp_beats.push_back({2'b00, 8'h01});
      exp_beats.push_back({2'b00, 8'h02});
      exp_beats.push_back({2'b11, 8'h00});
      exp_stat.push_back(4'b0111);
      compare_all("timeout");
      stim = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
      model(stim);
      send_bytes(stim, 0);
      drain(4);
      compare_all("after-timeout");

      // Reset in the middle of a payload.
      bus.m_axis_tready = 1'b0;
      stim = '{8'hA5, 8'h05, 8'h01};
      send_bytes(stim, 0);
      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(negedge clk);
      check("midreset m_tvalid", {31'd0, bus.m_axis_tvalid}, 32'd0);
      check("midreset s_tready", {31'd0, bus.s_axis_tready}, 32'd1);
      check("midreset no pulse", {30'd0, frame_ok, frame_err}, 32'd0);
      @(posedge clk);
      #1;
      obs_beats.delete();
      obs_stat.delete();
      bus.m_axis_tready = 1'b1;
      stim = '{8'h05, 8'hA5, 8'h01, 8'h7F, 8'h7E};
      model(stim);
      send_bytes(stim, 0);
      drain(4);
      compare_all("after-reset");

      // Random frame batches with random gaps, junk and backpressure.
      for (int b = 0; b < 8; b++) begin
         stim.delete();
         for (int f = 0; f < 4; f++) begin
            repeat ($urandom_range(2, 0)) begin
               j = 8'($urandom);
               if (j == SOF) j = 8'h5A;
               stim.push_back(j);
            end
            stim.push_back(SOF);
            if ($urandom_range(9, 0) == 0) begin
               len = ($urandom_range(1, 0) == 0) ? 8'd0 : 8'($urandom_range(255, MAXLEN + 1));
               stim.push_back(len);
            end else begin
               len = 8'($urandom_range(MAXLEN, 1));
               stim.push_back(len);
               c = len;
               for (int i = 0; i < int'(len); i++) begin
                  p = 8'($urandom);
                  c = c ^ p;
                  stim.push_back(p);
               end
               if ($urandom_range(3, 0) == 0) c = c ^ 8'($urandom_range(255, 1));
               stim.push_back(c);
            end
         end
         model(stim);
         bp_en = 1'b1;
         send_bytes(stim, 2);
         drain(20);
         compare_all($sformatf("random batch %0d", b));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
